// File: rtl/instr_encoder_if.sv
// Request channel into the instruction encoder: mnemonic plus operand fields over valid/ready.
// The source (master) holds every field stable while in_valid is high and in_ready is low.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;

    modport master (
        output in_valid, mnem, rs, rt, rd, imm, target,
        input  in_ready
    );

    modport slave (
        input  in_valid, mnem, rs, rt, rd, imm, target,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder/loader: encodes one request per cycle and writes it to imem at consecutive addresses.
// Latency 1 cycle from transfer to imem_we; in_ready depends only on state and start, never on in_valid.
module instr_encoder #(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [AW-1:0]     base,
    instr_encoder_if.slave    req,
    output logic              imem_we,
    output logic [AW-1:0]     imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [AW:0]       count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;

    logic            xfer;
    logic            legal;
    logic [31:0]     word;

    // Combinational encode of the presented request; legal is low for mnemonics 13-15.
    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (req.mnem)
            4'd0:    word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b100000};
            4'd1:    word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b100010};
            4'd2:    word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b100100};
            4'd3:    word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b100101};
            4'd4:    word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b100110};
            4'd5:    word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b101010};
            4'd6:    word = {6'b000000, req.rs, req.rt, req.rd, 5'b0, 6'b101011};
            4'd7:    word = {6'b100011, req.rs, req.rt, req.imm};
            4'd8:    word = {6'b101011, req.rs, req.rt, req.imm};
            4'd9:    word = {6'b001000, req.rs, req.rt, req.imm};
            4'd10:   word = {6'b000100, req.rs, req.rt, req.imm};
            4'd11:   word = {6'b000101, req.rs, req.rt, req.imm};
            4'd12:   word = {6'b000010, req.target};
            default: legal = 1'b0;
        endcase
    end

    assign req.in_ready = (state_q == LOAD) && !start;
    assign xfer         = req.in_valid && req.in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (xfer) begin
            if (legal) begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = word;
                ptr_d   = ptr_q + 1'b1;
                count_d = count_q + 1'b1;
                if (ptr_q == {AW{1'b1}}) begin
                    state_d = FULL;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        // start outranks stop; a write captured earlier this cycle is unaffected by either.
        if (start) begin
            state_d = LOAD;
            ptr_d   = base;
            count_d = '0;
            err_d   = 1'b0;
        end else if (stop && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (state_q == FULL);
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench: the driver pushes expected imem writes from a reference model; a negedge monitor pops and compares.
module tb_instr_encoder;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst, start, stop;
    logic [AW-1:0] base;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full, err;

    instr_encoder_if req_if ();

    instr_encoder #(.AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .base       (base),
        .req        (req_if),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    // Reference model state
    int  m_ptr   = 0;
    int  m_count = 0;
    bit  m_err   = 0;
    bit  m_full  = 0;

    int funct_tab[7] = '{32, 34, 36, 37, 38, 42, 43};
    int op_tab[5]    = '{35, 43, 8, 4, 5};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int m, input int s, input int t, input int d,
                                             input int i, input int tg);
        logic [31:0] w;
        if (m <= 6)
            w = (32'(s) << 21) + (32'(t) << 16) + (32'(d) << 11) + 32'(funct_tab[m]);
        else if (m <= 11)
            w = (32'(op_tab[m-7]) << 26) + (32'(s) << 21) + (32'(t) << 16) + 32'(i);
        else
            w = (32'd2 << 26) + 32'(tg);
        return w;
    endfunction

    // Model reaction to an accepted request.
    task automatic model_accept(input int m, input int s, input int t, input int d,
                                input int i, input int tg);
        wr_t e;
        if (m <= 12) begin
            e.addr = AW'(m_ptr);
            e.data = ref_word(m, s, t, d, i, tg);
            exp_q.push_back(e);
            if (m_ptr == (1 << AW) - 1) m_full = 1;
            m_ptr   = (m_ptr + 1) % (1 << AW);
            m_count = m_count + 1;
        end else begin
            m_err = 1;
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%08h expected=none", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic send(input int m, input int s, input int t, input int d, input int i,
                        input int tg, input int max_cyc, output bit accepted);
        req_if.mnem   = 4'(m);
        req_if.rs     = 5'(s);
        req_if.rt     = 5'(t);
        req_if.rd     = 5'(d);
        req_if.imm    = 16'(i);
        req_if.target = 26'(tg);
        req_if.in_valid = 1'b1;
        accepted = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (req_if.in_ready) begin
                model_accept(m, s, t, d, i, tg);
                accepted = 1;
            end
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        req_if.in_valid = 1'b0;
    endtask

    task automatic do_start(input int b);
        start = 1'b1;
        base  = AW'(b);
        @(posedge clk);
        #1;
        start   = 1'b0;
        m_ptr   = b;
        m_count = 0;
        m_err   = 0;
        m_full  = 0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop   = 1'b0;
        m_full = 0;
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        check({tag, "_count"}, 32'(count), 32'(m_count));
        check({tag, "_err"},   32'(err),   32'(m_err));
        check({tag, "_full"},  32'(full),  32'(m_full));
        @(posedge clk);
        #1;
    endtask

    task automatic must_accept(input int m, input int s, input int t, input int d, input int i, input int tg);
        bit acc;
        send(m, s, t, d, i, tg, 20, acc);
        check("accept_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        bit acc;
        rst = 1'b1; start = 1'b0; stop = 1'b0; base = '0;
        req_if.in_valid = 1'b0; req_if.mnem = '0; req_if.rs = '0; req_if.rt = '0;
        req_if.rd = '0; req_if.imm = '0; req_if.target = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", 32'(req_if.in_ready), 0);
        check("rst_we",       32'(imem_we), 0);
        check("rst_addr",     32'(imem_addr), 0);
        check("rst_wdata",    imem_wdata, 0);
        check("rst_count",    32'(count), 0);
        check("rst_full",     32'(full), 0);
        check("rst_err",      32'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back legal requests; expected words also pinned as literals.
        do_start(16);
        must_accept(0, 1, 2, 3, 0, 0);
        check("lit_add", ref_word(0, 1, 2, 3, 0, 0), 32'h00221820);
        must_accept(7, 4, 5, 0, 8, 0);
        check("lit_lw", ref_word(7, 4, 5, 0, 8, 0), 32'h8C850008);
        must_accept(12, 0, 0, 0, 0, 'h40);
        check("lit_j", ref_word(12, 0, 0, 0, 0, 'h40), 32'h08000040);
        check_status("seq3");
        check("seq3_count_lit", 32'(count), 3);

        must_accept(11, 8, 9, 0, 'hFFFF, 0);
        check("lit_bne", ref_word(11, 8, 9, 0, 'hFFFF, 0), 32'h1509FFFF);
        must_accept(6, 1, 2, 3, 0, 0);
        check("lit_sltu", ref_word(6, 1, 2, 3, 0, 0), 32'h0022182B);

        // Top-of-memory boundary.
        do_start((1 << AW) - 2);
        must_accept(1, 3, 4, 5, 0, 0);
        must_accept(9, 6, 7, 0, 'h1234, 0);
        @(negedge clk);
        check("full_flag", 32'(full), 1);
        check("full_in_ready", 32'(req_if.in_ready), 0);
        @(posedge clk);
        #1;
        send(2, 1, 1, 1, 0, 0, 4, acc);
        check("full_held", 32'(acc), 0);
        check_status("full");
        do_stop();
        do_start(0);
        check_status("after_full");

        // Illegal mnemonic between two adds.
        do_start(32);
        must_accept(0, 1, 1, 1, 0, 0);
        must_accept(14, 2, 2, 2, 0, 0);
        must_accept(0, 3, 3, 3, 0, 0);
        check_status("illegal");
        check("illegal_err_lit", 32'(err), 1);
        do_start(40);
        check_status("err_clear");

        // start together with in_valid: not consumed that cycle, ptr reloaded.
        req_if.mnem = 4'd4; req_if.rs = 5'd9; req_if.rt = 5'd10; req_if.rd = 5'd11;
        req_if.in_valid = 1'b1;
        start = 1'b1; base = AW'(80);
        @(negedge clk);
        check("start_in_ready", 32'(req_if.in_ready), 0);
        @(posedge clk);
        #1;
        start = 1'b0; m_ptr = 80; m_count = 0; m_err = 0; m_full = 0;
        must_accept(4, 9, 10, 11, 0, 0);

        // Reset right after a legal transfer.
        must_accept(5, 1, 2, 3, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = 0; m_count = 0; m_err = 0; m_full = 0;
        @(negedge clk);
        check("rr_in_ready", 32'(req_if.in_ready), 0);
        check("rr_we",       32'(imem_we), 0);
        check("rr_addr",     32'(imem_addr), 0);
        check("rr_wdata",    imem_wdata, 0);
        check("rr_count",    32'(count), 0);
        check("rr_full",     32'(full), 0);
        check("rr_err",      32'(err), 0);
        @(posedge clk);
        #1;

        // Randomized session.
        do_start($urandom_range(0, 150));
        for (int n = 0; n < 60; n++) begin
            int gap;
            must_accept($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                        $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1));
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        check_status("random");

        repeat (3) @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Sequential MIPS instruction encoder and instruction-memory loader; the encode-side counterpart of the opcode control decoder.
- Accepts one instruction at a time as a mnemonic plus register, immediate and target fields over a valid/ready handshake.
- Builds the 32-bit instruction word and writes it through a single-port write interface into instruction memory at consecutive addresses.
- Used by the test harness and boot path to load programs before the datapath runs.

## Interface
Parameters:
- AW, 8, instruction-memory word-address width; capacity 2^AW words

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse: open a load session at `base`
- stop  in  1  one-cycle pulse: close the session
- base  in  AW  first write address, sampled on `start`
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- mnem  in  4  mnemonic code:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu
  - 7 lw, 8 sw, 9 addi, 10 beq, 11 bne, 12 j
  - 13–15 illegal
- rs, rt, rd  in  5 each  register fields
- imm  in  16  immediate / branch offset
- target  in  26  jump target
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  AW  write address
- imem_wdata  out  32  encoded word
- count  out  AW+1  legal words written since last `start`
- full  out  1  session hit the top of memory
- err  out  1  sticky: an illegal mnemonic was accepted

## Operation
- States:
  - IDLE: reset state, `in_ready`=0.
  - LOAD: `in_ready` = !start.
  - FULL: `in_ready`=0, `full`=1.
- Transitions:
  - `start` from any state → LOAD; ptr←`base`, `count`←0, `err`←0.
  - `stop` in LOAD or FULL → IDLE.
  - `start` and `stop` in the same cycle: `start` wins.
  - Accepting a legal request with ptr = 2^AW−1 → FULL.
- Transfer: occurs when `in_valid` && `in_ready`.
- Encoding, legal mnemonics:
  - R-type: word = {6'b000000, rs, rt, rd, 5'b0, funct}; funct: add 100000, sub 100010, and 100100, or 100101, xor 100110, slt 101010, sltu 101011.
  - I-type: word = {op, rs, rt, imm}; op: lw 100011, sw 101011, addi 001000, beq 000100, bne 000101.
  - j: word = {6'b000010, target}.
  - Unused fields of the request are ignored.
- Legal transfer: the word is registered together with the current ptr; ptr←ptr+1, modulo 2^AW; `count`←count+1.
- Illegal transfer (mnem 13–15):
  - Handshake completes.
  - No write, ptr and `count` unchanged.
  - `err`←1, held until the next `start` or `rst`.
- `in_valid` while not ready: the request is not consumed. The source holds it stable until accepted.

## Timing
- Latency: a transfer at edge N gives `imem_we`=1 with `imem_addr`/`imem_wdata` valid during the cycle after edge N. `imem_we` is a single-cycle pulse per legal transfer.
- Throughput: one instruction per cycle in LOAD.
- `in_ready` is combinational from state and `start` only; it never depends on `in_valid`.
- When `imem_we`=0, `imem_addr`/`imem_wdata` hold their last values.
- A write registered before a `start` or `stop` still issues next cycle at its captured address.
- `full` asserts the cycle after the transfer that wrote address 2^AW−1. No wrap write ever occurs.
- `rst` reset values:
  - state IDLE, ptr 0.
  - `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0.
  - `count` 0, `full` 0, `err` 0.
- `rst` mid-session cancels any registered write: `imem_we`=0 the next cycle.

## Test plan
- Reset, `start` with `base`=0x10, then send three legal requests back to back:
  - add rs=1 rt=2 rd=3 → 0x00221820 at 0x10.
  - lw rs=4 rt=5 imm=0x0008 → 0x8C850008 at 0x11.
  - j target=0x0000040 → 0x08000040 at 0x12.
  - Expect one `imem_we` per cycle and `count`=3.
- `base`=2^AW−2, send 3 requests:
  - First two are written.
  - `full`=1 and `in_ready`=0 after the second.
  - Third is held with no `imem_we`.
  - `stop` → IDLE; `start` clears `full`.
- Send mnem=14 between two legal adds:
  - `err`=1.
  - The two adds land at consecutive addresses.
  - `count`=2.
  - `err` clears on the next `start`.
- Drive `start` and `in_valid` together in LOAD: `in_ready`=0 that cycle, the request is not consumed, and ptr←`base`.
- Assert `rst` the cycle after a legal transfer: no `imem_we`, and all outputs at reset values.
- Send bne rs=8 rt=9 imm=0xFFFF → 0x1509FFFF; sltu rs=1 rt=2 rd=3 → 0x0022182B.
